ex_mem_stage_buffer: RTL and testbench

Parametrised successor to the single-entry EX/MEM latch: a DEPTH-entry elastic pipeline buffer carrying a DATA_W-bit datapath payload and a CTRL_W-bit control bundle between the execute and memory stages. It adds a valid/ready handshake, a flush, and a global `hit` freeze, so memory-side back-pressure no longer forces an upstream pipeline-wide stall. It captures on the falling edge of `CLK`, like the other stage registers.

---
 rtl/ex_mem_stage_buffer.sv | 163 ++++++++++++++++
 tb/tb_ex_mem_stage_buffer.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_stage_buffer.sv
// ----------------------------------------------------------------------------
// ex_mem_stage_buffer
//
// DEPTH-entry elastic buffer between the execute and memory stages. Each entry
// carries a DATA_W-bit datapath payload and a CTRL_W-bit control bundle. Entries
// move under a valid/ready handshake. A flush discards every entry, and a
// low `hit` freezes the buffer (a flush still acts). All state changes on the
// falling edge of CLK, matching the other stage registers.
//
// Parameters:
//   DATA_W  payload width
//   CTRL_W  control bundle width
//   DEPTH   number of entries, 1..16
//   CNT_W   occupancy counter width (derived)
//
// Ports:
//   CLK        in   clock, falling-edge active
//   RST        in   asynchronous reset, active-high
//   hit        in   global enable; 0 freezes everything except flush
//   flush      in   discard all entries, wins over enq/deq
//   in_valid   in   upstream presents an entry
//   in_data    in   upstream payload
//   in_ctrl    in   upstream control bundle
//   in_ready   out  room for an entry (count < DEPTH)
//   out_valid  out  head entry valid (count != 0)
//   out_data   out  head payload
//   out_ctrl   out  head control, all-zero while empty
//   out_ready  in   downstream consumes the head entry
//   count      out  current occupancy
//   stall_cnt  out  saturating back-pressure counter (PIPE_STALL_CNT_EN only)
//   hitOut     out  combinational copy of hit
//
// Optional feature macro: PIPE_STALL_CNT_EN adds the 16-bit stall_cnt output.
// ----------------------------------------------------------------------------
module ex_mem_stage_buffer #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 8,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              hit,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  count,
`ifdef PIPE_STALL_CNT_EN
    output logic [15:0]       stall_cnt,
`endif
    output logic              hitOut
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int ENT_W = CTRL_W + DATA_W;

    logic [ENT_W-1:0] mem_q [DEPTH];
    logic [ENT_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [ENT_W-1:0] head;
    logic             enq;
    logic             deq;

    // Pointers wrap by explicit compare so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // in_ready looks only at occupancy, never at out_ready, so there is no
    // combinational path from the memory stage back to the execute stage.
    assign in_ready  = (count_q < CNT_W'(DEPTH));
    assign out_valid = (count_q != '0);
    assign enq       = in_valid & in_ready & hit;
    assign deq       = out_valid & out_ready & hit;

    assign head      = mem_q[rd_ptr_q];
    assign out_data  = head[DATA_W-1:0];
    // A bubble must never present MemWrite/RegWrite downstream.
    assign out_ctrl  = out_valid ? head[ENT_W-1:DATA_W] : '0;
    assign count     = count_q;
    assign hitOut    = hit;

    always_comb begin
        // NOTE: every signal gets its hold value first; a path that skips an
        // assignment would otherwise infer a latch.
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (flush) begin
            // Contents are left stale; zero occupancy makes them unreachable.
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (enq) begin
                mem_d[wr_ptr_q] = {in_ctrl, in_data};
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (deq) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            case ({enq, deq})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(negedge CLK or posedge RST) begin
        if (RST) begin
            // NOTE: the array is reset too, so out_data reads zero straight out
            // of reset instead of power-up garbage.
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling the
            // pre-edge values, independent of statement order.
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

`ifdef PIPE_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Counts edges where the memory stage back-pressures a valid head entry.
    // Saturates, and survives flush so it spans whole program runs.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (out_valid && !out_ready && hit && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(negedge CLK or posedge RST) begin
        if (RST) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ex_mem_stage_buffer.sv
// ----------------------------------------------------------------------------
// tb_ex_mem_stage_buffer
//
// Drives a DEPTH=2 and a DEPTH=3 instance from the same inputs. Each instance
// is compared every cycle against a queue model of the buffer. A vector table
// covers fill/drain, freeze and flush on the DEPTH=2 instance, hand-written
// sequences cover streaming with wrap-around, asynchronous reset and (when
// PIPE_STALL_CNT_EN is defined) the stall counter, then random traffic runs.
// Inputs change just after the rising edge; the DUT captures on the falling
// edge; outputs are sampled just after the next rising edge.
// ----------------------------------------------------------------------------
module tb_ex_mem_stage_buffer;

    typedef logic [39:0] entry_t;   // {ctrl[7:0], data[31:0]}

    typedef struct {
        logic        iv;
        logic [31:0] idata;
        logic [7:0]  ictrl;
        logic        ordy;
        logic        h;
        logic        fl;
        int          exp_cnt;
        logic        exp_ov;
        logic [31:0] exp_od;
        logic [7:0]  exp_oc;
        logic        exp_ir;
    } vec_t;

    logic        CLK;
    logic        RST;
    logic        hit;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_data;
    logic [7:0]  in_ctrl;
    logic        out_ready;

    logic        in_ready2, out_valid2, hit_out2;
    logic [31:0] out_data2;
    logic [7:0]  out_ctrl2;
    logic [1:0]  count2;
    logic        in_ready3, out_valid3, hit_out3;
    logic [31:0] out_data3;
    logic [7:0]  out_ctrl3;
    logic [1:0]  count3;
`ifdef PIPE_STALL_CNT_EN
    logic [15:0] stall2, stall3;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    entry_t mq [2][$];
    int     mdepth [2] = '{2, 3};

    ex_mem_stage_buffer #(.DATA_W(32), .CTRL_W(8), .DEPTH(2)) u_dut2 (
        .CLK(CLK), .RST(RST), .hit(hit), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .in_ctrl(in_ctrl),
        .in_ready(in_ready2), .out_valid(out_valid2), .out_data(out_data2),
        .out_ctrl(out_ctrl2), .out_ready(out_ready), .count(count2),
`ifdef PIPE_STALL_CNT_EN
        .stall_cnt(stall2),
`endif
        .hitOut(hit_out2)
    );

    ex_mem_stage_buffer #(.DATA_W(32), .CTRL_W(8), .DEPTH(3)) u_dut3 (
        .CLK(CLK), .RST(RST), .hit(hit), .flush(flush),
        .in_valid(in_valid), .in_data(in_data), .in_ctrl(in_ctrl),
        .in_ready(in_ready3), .out_valid(out_valid3), .out_data(out_data3),
        .out_ctrl(out_ctrl3), .out_ready(out_ready), .count(count3),
`ifdef PIPE_STALL_CNT_EN
        .stall_cnt(stall3),
`endif
        .hitOut(hit_out3)
    );

    initial CLK = 1'b1;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_dut(input string tag, input int depth, input int sz, input entry_t hd,
                             input logic [1:0] cnt, input logic ir, input logic ov,
                             input logic [31:0] od, input logic [7:0] oc, input logic ho);
        check({tag, "_count"}, 40'(cnt), 40'(sz));
        check({tag, "_in_ready"}, 40'(ir), 40'(sz < depth));
        check({tag, "_out_valid"}, 40'(ov), 40'(sz != 0));
        check({tag, "_out_ctrl"}, 40'(oc), (sz != 0) ? 40'(hd[39:32]) : 40'd0);
        check({tag, "_hitOut"}, 40'(ho), 40'(hit));
        if (sz != 0) check({tag, "_out_data"}, 40'(od), 40'(hd[31:0]));
    endtask

    task automatic compare_models();
        entry_t h2, h3;
        h2 = (mq[0].size() != 0) ? mq[0][0] : '0;
        h3 = (mq[1].size() != 0) ? mq[1][0] : '0;
        check_dut("d2", 2, mq[0].size(), h2, count2, in_ready2, out_valid2, out_data2, out_ctrl2, hit_out2);
        check_dut("d3", 3, mq[1].size(), h3, count3, in_ready3, out_valid3, out_data3, out_ctrl3, hit_out3);
    endtask

    // Buffer behaviour at one falling edge, in queue terms.
    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            if (RST || flush) begin
                mq[k].delete();
            end else if (hit) begin
                bit room = (mq[k].size() < mdepth[k]);
                if (mq[k].size() != 0 && out_ready) void'(mq[k].pop_front());
                if (in_valid && room) mq[k].push_back({in_ctrl, in_data});
            end
        end
    endtask

    task automatic drive(input logic iv, input logic [31:0] d, input logic [7:0] c,
                         input logic ordy, input logic h, input logic fl);
        in_valid  = iv;
        in_data   = d;
        in_ctrl   = c;
        out_ready = ordy;
        hit       = h;
        flush     = fl;
    endtask

    task automatic cycle();
        model_step();
        @(negedge CLK);
        @(posedge CLK);
        #1;
        compare_models();
    endtask

    vec_t vecs [14];

    initial begin
        // Fill/drain, freeze and flush on the DEPTH=2 instance. Expected values
        // describe the outputs after the falling edge that consumes the vector.
        vecs[0]  = '{1'b1, 32'hA, 8'h81, 1'b0, 1'b1, 1'b0, 1, 1'b1, 32'hA, 8'h81, 1'b1};
        vecs[1]  = '{1'b1, 32'hB, 8'h82, 1'b0, 1'b1, 1'b0, 2, 1'b1, 32'hA, 8'h81, 1'b0};
        vecs[2]  = '{1'b1, 32'hC, 8'h83, 1'b0, 1'b1, 1'b0, 2, 1'b1, 32'hA, 8'h81, 1'b0};
        vecs[3]  = '{1'b0, 32'h0, 8'h00, 1'b1, 1'b1, 1'b0, 1, 1'b1, 32'hB, 8'h82, 1'b1};
        vecs[4]  = '{1'b0, 32'h0, 8'h00, 1'b1, 1'b1, 1'b0, 0, 1'b0, 32'h0, 8'h00, 1'b1};
        vecs[5]  = '{1'b1, 32'hD, 8'h84, 1'b0, 1'b1, 1'b0, 1, 1'b1, 32'hD, 8'h84, 1'b1};
        vecs[6]  = '{1'b1, 32'hE, 8'h85, 1'b1, 1'b0, 1'b0, 1, 1'b1, 32'hD, 8'h84, 1'b1};
        vecs[7]  = '{1'b1, 32'hE, 8'h85, 1'b1, 1'b0, 1'b0, 1, 1'b1, 32'hD, 8'h84, 1'b1};
        vecs[8]  = '{1'b1, 32'hE, 8'h85, 1'b1, 1'b0, 1'b0, 1, 1'b1, 32'hD, 8'h84, 1'b1};
        vecs[9]  = '{1'b1, 32'hF, 8'h86, 1'b1, 1'b1, 1'b0, 1, 1'b1, 32'hF, 8'h86, 1'b1};
        vecs[10] = '{1'b1, 32'h10, 8'h87, 1'b0, 1'b1, 1'b0, 2, 1'b1, 32'hF, 8'h86, 1'b0};
        vecs[11] = '{1'b1, 32'h11, 8'h88, 1'b1, 1'b0, 1'b1, 0, 1'b0, 32'h0, 8'h00, 1'b1};
        vecs[12] = '{1'b0, 32'h0, 8'h00, 1'b0, 1'b1, 1'b0, 0, 1'b0, 32'h0, 8'h00, 1'b1};
        vecs[13] = '{1'b1, 32'h12, 8'h89, 1'b0, 1'b1, 1'b0, 1, 1'b1, 32'h12, 8'h89, 1'b1};

        // Reset asserted with an entry offered: state is cleared before any edge.
        RST = 1'b1;
        drive(1'b1, 32'hDEAD, 8'hFF, 1'b0, 1'b1, 1'b0);
        #2;
        check("rst_count", 40'(count2), 40'd0);
        check("rst_out_valid", 40'(out_valid2), 40'd0);
        check("rst_out_ctrl", 40'(out_ctrl2), 40'd0);
        check("rst_out_data", 40'(out_data2), 40'd0);
        check("rst_in_ready", 40'(in_ready2), 40'd1);
        @(posedge CLK);
        #1;
        RST = 1'b0;

        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].iv, vecs[i].idata, vecs[i].ictrl, vecs[i].ordy, vecs[i].h, vecs[i].fl);
            cycle();
            check($sformatf("vec%0d_count", i), 40'(count2), 40'(vecs[i].exp_cnt));
            check($sformatf("vec%0d_out_valid", i), 40'(out_valid2), 40'(vecs[i].exp_ov));
            check($sformatf("vec%0d_out_ctrl", i), 40'(out_ctrl2), 40'(vecs[i].exp_oc));
            check($sformatf("vec%0d_in_ready", i), 40'(in_ready2), 40'(vecs[i].exp_ir));
            if (vecs[i].exp_ov) check($sformatf("vec%0d_out_data", i), 40'(out_data2), 40'(vecs[i].exp_od));
        end

        // Streaming through DEPTH=3: eight back-to-back pushes wrap twice.
        drive(1'b0, 32'h0, 8'h0, 1'b0, 1'b1, 1'b1);
        cycle();
        for (int i = 1; i <= 8; i++) begin
            drive(1'b1, 32'(i), 8'(8'h40 + i), 1'b1, 1'b1, 1'b0);
            cycle();
            check($sformatf("stream%0d_count", i), 40'(count3), 40'd1);
            check($sformatf("stream%0d_data", i), 40'(out_data3), 40'(i));
            check($sformatf("stream%0d_ctrl", i), 40'(out_ctrl3), 40'(8'h40 + i));
        end
        drive(1'b0, 32'h0, 8'h0, 1'b1, 1'b1, 1'b0);
        cycle();
        check("stream_drained", 40'(out_valid3), 40'd0);

        // Reset in the middle of traffic, observed before the next edge.
        drive(1'b1, 32'h55, 8'h12, 1'b0, 1'b1, 1'b0);
        cycle();
        cycle();
        RST = 1'b1;
        #1;
        check("midrst_count3", 40'(count3), 40'd0);
        check("midrst_out_valid3", 40'(out_valid3), 40'd0);
        check("midrst_out_ctrl3", 40'(out_ctrl3), 40'd0);
        check("midrst_in_ready3", 40'(in_ready3), 40'd1);
        cycle();
        RST = 1'b0;

        // Random traffic against the queue model.
        for (int n = 0; n < 600; n++) begin
            RST = ($urandom_range(0, 63) == 0);
            drive($urandom_range(0, 3) != 0, $urandom, 8'($urandom),
                  $urandom_range(0, 1) == 1, $urandom_range(0, 7) != 0,
                  $urandom_range(0, 31) == 0);
            cycle();
        end
        RST = 1'b0;

`ifdef PIPE_STALL_CNT_EN
        RST = 1'b1;
        drive(1'b0, 32'h0, 8'h0, 1'b0, 1'b1, 1'b0);
        cycle();
        RST = 1'b0;
        drive(1'b1, 32'h77, 8'h01, 1'b0, 1'b1, 1'b0);
        cycle();                             // head was empty before this edge
        drive(1'b0, 32'h0, 8'h0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) cycle();
        drive(1'b0, 32'h0, 8'h0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) cycle();
        check("stall_cnt2_5", 40'(stall2), 40'd5);
        check("stall_cnt3_5", 40'(stall3), 40'd5);
        drive(1'b0, 32'h0, 8'h0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 65535; i++) cycle();
        check("stall_cnt2_sat", 40'(stall2), 40'hFFFF);
        check("stall_cnt3_sat", 40'(stall3), 40'hFFFF);
        cycle();
        check("stall_cnt2_hold", 40'(stall2), 40'hFFFF);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
